psram_req_arb: RTL
==================

// Module: psram_req_arb
// PURPOSE
// - Round-robin arbiter and transaction sequencer that shares the single PSRAM
//   OPI/QPI core between NUM_REQ bus requesters (e.g. ifetch, data, DMA).
// - Checks each request against the OPI linear-burst rules, issues one
//   transaction at a time to the core, and routes completion back to the owner.
// - Sits between the bus-side adapters and the PSRAM core FSM.
// PARAMETERS
// - NUM_REQ     2   number of requesters (2..4)
// - ADDR_WIDTH  23  byte address width (8 MB device)
// - LEN_WIDTH   8   burst length field width, in bytes
// - MAX_LEN     64  max bytes per transaction (tCEM-bounded); 1..2**LEN_WIDTH-1
// - STARVE_LIM  4   grants lost before priority override (PSRAM_ARB_PRIO_EN only)
// PORTS
// - clk_i        in   1                   core clock
// - rst_i        in   1                   synchronous reset, active-high
// - en_i         in   1                   CTRL.EN; low blocks new grants
// - req_valid_i  in   NUM_REQ             per-requester request valid
// - req_ready_o  out  NUM_REQ             request accepted (1-cycle pulse)
// - req_we_i     in   NUM_REQ             1 = write, 0 = read
// - req_addr_i   in   NUM_REQ*ADDR_WIDTH  packed start byte addresses
// - req_len_i    in   NUM_REQ*LEN_WIDTH   packed burst lengths, bytes
// - req_done_o   out  NUM_REQ             completion pulse to owner
// - req_err_o    out  NUM_REQ             rule-violation flag, valid with req_done_o
// - core_valid_o out  1                   transaction valid to core
// - core_ready_i in   1                   core accepts transaction
// - core_we_o    out  1                   forwarded we
// - core_addr_o  out  ADDR_WIDTH          forwarded address
// - core_len_o   out  LEN_WIDTH           forwarded length
// - core_done_i  in   1                   core finished (CE deasserted)
// - gnt_id_o     out  $clog2(NUM_REQ)     current owner index
// - busy_o       out  1                   state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0, FSM = IDLE, round-robin pointer = 0, starve counters 0.
// - FSM: IDLE -> CHECK -> ISSUE -> WAIT -> IDLE.
// - IDLE: if en_i and any req_valid_i, pick the first valid index at or after
//   rr_ptr (wrap modulo NUM_REQ); latch we/addr/len; pulse req_ready_o[id];
//   gnt_id_o = id; go to CHECK. No valid requests, or en_i low: stay in IDLE.
// - CHECK (1 cycle): the request is an error if any of these holds:
//   - len == 0
//   - len > MAX_LEN
//   - addr[0] == 1 (odd start address)
//   - we and len < 2 (minimum write burst is 2 B)
//   - addr + len overflows ADDR_WIDTH (use an ADDR_WIDTH+1-bit sum)
// - CHECK error: pulse req_done_o[id] and req_err_o[id] together; go to IDLE;
//   nothing is issued to the core.
// - CHECK ok: go to ISSUE.
// - ISSUE: hold core_valid_o and the core_* fields stable until core_ready_i is
//   high in the same cycle, then go to WAIT. core_valid_o is never withdrawn
//   once asserted.
// - WAIT: on core_done_i, pulse req_done_o[id] (req_err_o = 0), set
//   rr_ptr = id+1 (wrap), go to IDLE.
// - core_done_i outside WAIT is ignored.
// - Latency: grant to core_valid_o is 2 cycles. Minimum gap from done to the
//   next grant is 1 cycle (IDLE).
// - en_i falling mid-transaction does not abort; the in-flight access completes.
// - Requests that drop req_valid_i before they are granted are not remembered.
// - Synchronous reset in any state returns to IDLE immediately and drops
//   core_valid_o. The core has its own reset and is reset with this block.
// CONFIGURATION
// - PSRAM_ARB_PRIO_EN defined:
//   - Requester 0 is high priority and wins whenever valid.
//   - Each other requester counts grants it lost while valid.
//   - When a count reaches STARVE_LIM, that requester wins the next arbitration
//     over requester 0, and its counter clears on grant.
//   - Ties among starved requesters resolve by round-robin.
// - PSRAM_ARB_PRIO_EN undefined: pure round-robin; no counters are synthesized.
// TESTING
// - Single req0 read, addr=0x10, len=8 -> ready pulse, core_valid 2 cycles
//   later, done[0] 1 cycle after core_done_i, err=0.
// - req0 and req1 valid continuously, 4 transactions -> grants 0,1,0,1.
//   With PRIO_EN and STARVE_LIM=4 -> grants 0,0,0,0,1.
// - Write len=1 at 0x20; read at 0x21; len=65 (MAX_LEN=64) ->
//   each gets done+err, core_valid_o stays 0.
// - core_ready_i held low 5 cycles in ISSUE -> core_valid_o and core_addr_o
//   stable for all 5 cycles; accepted on cycle 6.
// - en_i low with req1 valid -> no grant. Raise en_i -> grant within 1 cycle.
//   Drop en_i during WAIT -> transaction still completes.
// - rst_i asserted in WAIT -> next cycle busy_o=0, core_valid_o=0, rr_ptr=0;
//   a stale core_done_i afterwards produces no req_done_o.

Source files
------------

// File: rtl/psram_req_arb.sv
// psram_req_arb: round-robin arbiter and transaction sequencer that shares one PSRAM core
// between NUM_REQ requesters. Optional macro PSRAM_ARB_PRIO_EN: requester 0 priority with starvation override.
module psram_req_arb #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 23,
   parameter int LEN_WIDTH  = 8,
   parameter int MAX_LEN    = 64,
   parameter int STARVE_LIM = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            en_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic [NUM_REQ-1:0]              req_we_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
   output logic [NUM_REQ-1:0]              req_done_o,
   output logic [NUM_REQ-1:0]              req_err_o,
   output logic                            core_valid_o,
   input  logic                            core_ready_i,
   output logic                            core_we_o,
   output logic [ADDR_WIDTH-1:0]           core_addr_o,
   output logic [LEN_WIDTH-1:0]            core_len_o,
   input  logic                            core_done_i,
   output logic [$clog2(NUM_REQ)-1:0]      gnt_id_o,
   output logic                            busy_o
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int AW1 = ADDR_WIDTH + 1;

   if (NUM_REQ < 2 || NUM_REQ > 4 || STARVE_LIM < 1 || MAX_LEN < 1 ||
       MAX_LEN > (2**LEN_WIDTH) - 1) begin : g_param_chk
      $error("psram_req_arb: parameter out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT} state_t;

   state_t                  state_q, state_d;
   logic [IDW-1:0]          rr_q, rr_d, id_q, id_d, arb_id;
   logic                    we_q, we_d, arb_hit, gnt, chk_err;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [NUM_REQ-1:0]      done_q, done_d, err_q, err_d;
   logic [AW1-1:0]          end_sum;

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
      return (v == IDW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
   endfunction

   // First set bit of m at or after p, wrapping; MSB of the result is the hit flag.
   function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] m, input logic [IDW-1:0] p);
      logic [IDW-1:0] i, r;
      logic           h;
      i = p;
      r = p;
      h = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!h && m[i]) begin
            h = 1'b1;
            r = i;
         end
         i = wrap_inc(i);
      end
      return {h, r};
   endfunction

`ifdef PSRAM_ARB_PRIO_EN
   localparam int CW = $clog2(STARVE_LIM + 1);

   logic [NUM_REQ-1:0][CW-1:0] starve_q, starve_d;
   logic [NUM_REQ-1:0]         starved;
   logic [IDW:0]               pick_starved, pick_all;

   always_comb begin
      starved = '0;
      for (int i = 1; i < NUM_REQ; i++)
         starved[i] = req_valid_i[i] && (starve_q[i] >= CW'(STARVE_LIM));
      pick_starved = rr_pick(starved, rr_q);
      pick_all     = rr_pick(req_valid_i, rr_q);
      if (pick_starved[IDW]) begin
         {arb_hit, arb_id} = pick_starved;
      end else if (req_valid_i[0]) begin
         arb_hit = 1'b1;
         arb_id  = '0;
      end else begin
         {arb_hit, arb_id} = pick_all;
      end
   end

   // Requester 0 never starves, so its counter stays at zero.
   always_comb begin
      starve_d = starve_q;
      if (gnt) begin
         for (int i = 1; i < NUM_REQ; i++) begin
            if (arb_id == IDW'(i))
               starve_d[i] = '0;
            else if (req_valid_i[i] && (starve_q[i] < CW'(STARVE_LIM)))
               starve_d[i] = starve_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) starve_q <= '0;
      else       starve_q <= starve_d;
   end
`else
   always_comb {arb_hit, arb_id} = rr_pick(req_valid_i, rr_q);
`endif

   assign gnt     = (state_q == S_IDLE) && en_i && arb_hit && !rst_i;
   assign end_sum = {1'b0, addr_q} + AW1'(len_q);
   assign chk_err = (len_q == '0) || (len_q > LEN_WIDTH'(MAX_LEN)) || addr_q[0] ||
                    (we_q && (len_q < LEN_WIDTH'(2))) || end_sum[ADDR_WIDTH];

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      we_d    = we_q;
      addr_d  = addr_q;
      len_d   = len_q;
      done_d  = '0;
      err_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (gnt) begin
               id_d    = arb_id;
               we_d    = req_we_i[arb_id];
               addr_d  = req_addr_i[int'(arb_id)*ADDR_WIDTH +: ADDR_WIDTH];
               len_d   = req_len_i[int'(arb_id)*LEN_WIDTH +: LEN_WIDTH];
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (chk_err) begin
               done_d[id_q] = 1'b1;
               err_d[id_q]  = 1'b1;
               state_d      = S_IDLE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (core_ready_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (core_done_i) begin
               done_d[id_q] = 1'b1;
               rr_d         = wrap_inc(id_q);
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         done_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++)
         req_ready_o[i] = gnt && (arb_id == IDW'(i));
   end

   assign gnt_id_o     = gnt ? arb_id : id_q;
   assign core_valid_o = (state_q == S_ISSUE);
   assign core_we_o    = we_q;
   assign core_addr_o  = addr_q;
   assign core_len_o   = len_q;
   assign req_done_o   = done_q;
   assign req_err_o    = err_q;
   assign busy_o       = (state_q != S_IDLE);

endmodule
